// File: rtl/cc_sequencer_if.sv
// cc_sequencer_if: upstream pixel, pipeline issue/return and downstream pixel signals of the colour-convert sequencer
interface cc_sequencer_if #(
  parameter int PID_W = 19,
  parameter int RW = 4,
  parameter int GW = 5,
  parameter int BW = 4
);
  logic us_valid;
  logic [PID_W-1:0] us_pixelID;
  logic [31:0] us_red;
  logic [31:0] us_green;
  logic [31:0] us_blue;
  logic us_stall;
  logic mul_valid;
  logic [1:0] mul_chan;
  logic [31:0] mul_a;
  logic [31:0] res_int;
  logic ds_valid;
  logic [PID_W-1:0] ds_pixelID;
  logic [RW-1:0] ds_red;
  logic [GW-1:0] ds_green;
  logic [BW-1:0] ds_blue;
  logic ds_stall;
  modport slave (
    input us_valid, us_pixelID, us_red, us_green, us_blue, res_int, ds_stall,
    output us_stall, mul_valid, mul_chan, mul_a, ds_valid, ds_pixelID, ds_red, ds_green, ds_blue
  );
  modport master (
    output us_valid, us_pixelID, us_red, us_green, us_blue, res_int, ds_stall,
    input us_stall, mul_valid, mul_chan, mul_a, ds_valid, ds_pixelID, ds_red, ds_green, ds_blue
  );
endinterface

// File: rtl/cc_sequencer.sv
// cc_sequencer: credit-gated R/G/B issue into the shared convert pipeline, result saturation and pixel reassembly
module cc_sequencer #(
  parameter int PID_W = 19,
  parameter int LAT = 10,
  parameter int DEPTH = 4,
  parameter int RW = 4,
  parameter int GW = 5,
  parameter int BW = 4
) (
  input logic clk,
  input logic rst,
  cc_sequencer_if.slave bus
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int EW = PID_W + RW + GW + BW;
  typedef enum logic [1:0] {IDLE, R, G, B} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] credits_q, credits_d;
  logic [31:0] green_q, green_d, blue_q, blue_d, mul_a_q, mul_a_d;
  logic mul_valid_q, mul_valid_d;
  logic [1:0] mul_chan_q, mul_chan_d;
  logic [2:0] sr_q [LAT];
  logic [2:0] sr_d [LAT];
  logic [RW-1:0] red_hold_q, red_hold_d;
  logic [GW-1:0] green_hold_q, green_hold_d;
  logic [PID_W-1:0] tag_q [DEPTH];
  logic [PID_W-1:0] tag_d [DEPTH];
  logic [PW-1:0] tag_wr_q, tag_wr_d, tag_rd_q, tag_rd_d;
  logic [CW-1:0] tag_cnt_q, tag_cnt_d;
  logic [EW-1:0] of_q [DEPTH];
  logic [EW-1:0] of_d [DEPTH];
  logic [PW-1:0] of_wr_q, of_wr_d, of_rd_q, of_rd_d;
  logic [CW-1:0] of_cnt_q, of_cnt_d;
  logic accept, pop, res_v, push_px;
  logic [1:0] res_chan;
  function automatic logic [31:0] sat(input logic [31:0] v, input int w);
    logic [31:0] mx;
    mx = (32'd1 << w) - 32'd1;
    return v[31] ? 32'd0 : (v > mx ? mx : v);
  endfunction
  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction
  assign bus.us_stall = !((state_q == IDLE || state_q == B) && credits_q != '0);
  assign accept = bus.us_valid && !bus.us_stall;
  assign pop = of_cnt_q != '0 && !bus.ds_stall;
  assign res_v = sr_q[LAT-1][2];
  assign res_chan = sr_q[LAT-1][1:0];
  assign push_px = res_v && res_chan == 2'd2;
  always_comb begin
    state_d = accept ? R : state_q == R ? G : state_q == G ? B : IDLE;
    credits_d = credits_q - CW'(accept) + CW'(pop);
    green_d = accept ? bus.us_green : green_q;
    blue_d = accept ? bus.us_blue : blue_q;
    mul_valid_d = state_d != IDLE;
    mul_chan_d = state_d == R ? 2'd0 : state_d == G ? 2'd1 : state_d == B ? 2'd2 : mul_chan_q;
    // red goes straight from the upstream bus, it is issued on the cycle right after accept
    mul_a_d = accept ? bus.us_red : state_d == G ? green_q : state_d == B ? blue_q : mul_a_q;
    sr_d[0] = {mul_valid_q, mul_chan_q};
    for (int i = 1; i < LAT; i++) sr_d[i] = sr_q[i-1];
    red_hold_d = (res_v && res_chan == 2'd0) ? RW'(sat(bus.res_int, RW)) : red_hold_q;
    green_hold_d = (res_v && res_chan == 2'd1) ? GW'(sat(bus.res_int, GW)) : green_hold_q;
    tag_d = tag_q;
    if (accept) tag_d[tag_wr_q] = bus.us_pixelID;
    tag_wr_d = accept ? nxt(tag_wr_q) : tag_wr_q;
    tag_rd_d = push_px ? nxt(tag_rd_q) : tag_rd_q;
    tag_cnt_d = tag_cnt_q + CW'(accept) - CW'(push_px);
    of_d = of_q;
    if (push_px) of_d[of_wr_q] = {tag_q[tag_rd_q], red_hold_q, green_hold_q, BW'(sat(bus.res_int, BW))};
    of_wr_d = push_px ? nxt(of_wr_q) : of_wr_q;
    of_rd_d = pop ? nxt(of_rd_q) : of_rd_q;
    of_cnt_d = of_cnt_q + CW'(push_px) - CW'(pop);
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      credits_q <= CW'(DEPTH);
      green_q <= '0;
      blue_q <= '0;
      mul_valid_q <= 1'b0;
      mul_chan_q <= '0;
      mul_a_q <= '0;
      sr_q <= '{default: '0};
      red_hold_q <= '0;
      green_hold_q <= '0;
      tag_q <= '{default: '0};
      tag_wr_q <= '0;
      tag_rd_q <= '0;
      tag_cnt_q <= '0;
      of_q <= '{default: '0};
      of_wr_q <= '0;
      of_rd_q <= '0;
      of_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      credits_q <= credits_d;
      green_q <= green_d;
      blue_q <= blue_d;
      mul_valid_q <= mul_valid_d;
      mul_chan_q <= mul_chan_d;
      mul_a_q <= mul_a_d;
      sr_q <= sr_d;
      red_hold_q <= red_hold_d;
      green_hold_q <= green_hold_d;
      tag_q <= tag_d;
      tag_wr_q <= tag_wr_d;
      tag_rd_q <= tag_rd_d;
      tag_cnt_q <= tag_cnt_d;
      of_q <= of_d;
      of_wr_q <= of_wr_d;
      of_rd_q <= of_rd_d;
      of_cnt_q <= of_cnt_d;
    end
  end
  assign bus.mul_valid = mul_valid_q;
  assign bus.mul_chan = mul_chan_q;
  assign bus.mul_a = mul_a_q;
  assign bus.ds_valid = of_cnt_q != '0;
  assign {bus.ds_pixelID, bus.ds_red, bus.ds_green, bus.ds_blue} = of_q[of_rd_q];
  // credits bound pixels in flight plus buffered to DEPTH, so none of these can fire
  a_of_full: assert property (@(posedge clk) disable iff (!rst) !(push_px && of_cnt_q == CW'(DEPTH)));
  a_tag_empty: assert property (@(posedge clk) disable iff (!rst) !(push_px && tag_cnt_q == '0));
  a_tag_full: assert property (@(posedge clk) disable iff (!rst) !(accept && tag_cnt_q == CW'(DEPTH)));
  a_credits: assert property (@(posedge clk) disable iff (!rst) credits_q <= CW'(DEPTH));
endmodule

// File: tb/tb_cc_sequencer.sv
// tb_cc_sequencer: randomized scoreboard bench; a pixel-level model predicts issue, stall and output pixels
module tb_cc_sequencer;
  localparam int PID_W = 19, LAT = 10, DEPTH = 4, RW = 4, GW = 5, BW = 4;
  localparam int EW = PID_W + RW + GW + BW;
  logic clk = 1'b0;
  logic rst = 1'b1;
  cc_sequencer_if #(.PID_W(PID_W), .RW(RW), .GW(GW), .BW(BW)) bus ();
  cc_sequencer #(.PID_W(PID_W), .LAT(LAT), .DEPTH(DEPTH), .RW(RW), .GW(GW), .BW(BW)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );
  always #5 clk = ~clk;
  typedef struct { logic [EW-1:0] px; int ready; } exp_t;
  exp_t sb[$];
  int cyc = 0;
  int vectors = 0;
  int miscompares = 0;
  int last_acc = -100;
  int n_acc = 0;
  int n_pop = 0;
  logic [31:0] px_ch [3];
  logic [31:0] sched [int];
  always @(posedge clk) cyc <= cyc + 1;
  task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask
  function automatic int sat(input int v, input int w);
    int mx;
    mx = (1 << w) - 1;
    return v < 0 ? 0 : (v > mx ? mx : v);
  endfunction
  function automatic logic [31:0] rnd_res();
    case ($urandom_range(3))
      0: return 32'($urandom_range(40));
      1: return -32'($urandom_range(100, 1));
      2: return $urandom;
      default: return 32'($urandom_range(33, 14));
    endcase
  endfunction
  // pipeline stand-in: unit scale and exact convert, so res_int is the issued operand LAT cycles later
  always @(negedge clk) begin
    if (sched.exists(cyc)) begin
      bus.res_int = sched[cyc];
      sched.delete(cyc);
    end else bus.res_int = $urandom;
    if (bus.mul_valid) sched[cyc + LAT] = bus.mul_a;
  end
  always @(negedge clk) begin
    if (!rst) begin
      check("reset_issue", {bus.us_stall, bus.mul_valid, bus.mul_chan, bus.mul_a}, '0);
      check("reset_ds", {bus.ds_valid, bus.ds_pixelID, bus.ds_red, bus.ds_green, bus.ds_blue}, '0);
      sb.delete();
      last_acc = -100;
      n_acc = 0;
      n_pop = 0;
    end else begin
      int d;
      bit stall_e, dsv_e;
      d = cyc - last_acc;
      stall_e = d == 1 || d == 2 || n_acc - n_pop == DEPTH;
      check("us_stall", 96'(bus.us_stall), 96'(stall_e));
      check("mul_valid", 96'(bus.mul_valid), 96'(d >= 1 && d <= 3));
      if (d >= 1 && d <= 3) check("mul_issue", {bus.mul_chan, bus.mul_a}, {2'(d - 1), px_ch[d-1]});
      dsv_e = sb.size() > 0 && sb[0].ready <= cyc;
      check("ds_valid", 96'(bus.ds_valid), 96'(dsv_e));
      if (dsv_e) begin
        check("ds_pixel", {bus.ds_pixelID, bus.ds_red, bus.ds_green, bus.ds_blue}, sb[0].px);
        if (!bus.ds_stall) begin
          void'(sb.pop_front());
          n_pop++;
        end
      end
      if (bus.us_valid && !stall_e) begin
        sb.push_back('{px: {bus.us_pixelID, RW'(sat(bus.us_red, RW)), GW'(sat(bus.us_green, GW)),
                            BW'(sat(bus.us_blue, BW))}, ready: cyc + 4 + LAT});
        px_ch[0] = bus.us_red;
        px_ch[1] = bus.us_green;
        px_ch[2] = bus.us_blue;
        last_acc = cyc;
        n_acc++;
      end
    end
  end
  task automatic cycles(input int n, input int vpct, input int spct);
    repeat (n) begin
      @(posedge clk);
      #1;
      bus.us_valid = int'($urandom_range(99)) < vpct;
      bus.us_pixelID = PID_W'($urandom);
      bus.us_red = rnd_res();
      bus.us_green = rnd_res();
      bus.us_blue = rnd_res();
      bus.ds_stall = int'($urandom_range(99)) < spct;
    end
  endtask
  task automatic drain();
    repeat (300) begin
      if (sb.size() == 0) break;
      cycles(1, 0, 0);
    end
    vectors++;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d pixels outstanding, expected 0", sb.size());
    end
  endtask
  initial begin
    bus.us_valid = 1'b0;
    bus.us_pixelID = '0;
    bus.us_red = '0;
    bus.us_green = '0;
    bus.us_blue = '0;
    bus.ds_stall = 1'b0;
    bus.res_int = '0;
    #2 rst = 1'b0;
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    bus.us_valid = 1'b1;
    bus.us_pixelID = PID_W'(5);
    bus.us_red = 32'd7;
    bus.us_green = 32'd40;
    bus.us_blue = -32'd3;
    cycles(20, 0, 0);
    cycles(24, 100, 0);
    cycles(20, 0, 0);
    cycles(30, 100, 100);
    cycles(1, 100, 0);
    cycles(10, 100, 100);
    drain();
    cycles(20, 100, 100);
    cycles(2, 100, 0);
    cycles(6, 100, 100);
    drain();
    cycles(1500, 60, 40);
    drain();
    cycles(6, 100, 0);
    @(posedge clk);
    #3 rst = 1'b0;
    bus.us_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    bus.us_valid = 1'b1;
    bus.us_pixelID = PID_W'(77);
    bus.us_red = 32'd3;
    bus.us_green = 32'd100;
    bus.us_blue = 32'd9;
    cycles(30, 0, 0);
    drain();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
